// File: rtl/pyramid_half_scheduler.sv
// Steps the image halving engine through every octave level. It launches one pass
// at a time, tracks which levels hold valid data, and watches each pass with a watchdog.
module pyramid_half_scheduler #(
  parameter int NUM_OCTAVES    = 3,
  parameter int OLD_WIDTH      = 64,
  parameter int OLD_HEIGHT     = 64,
  parameter int TIMEOUT_CYCLES = 4*OLD_WIDTH*OLD_HEIGHT+64,
  localparam int LW = (NUM_OCTAVES > 1) ? $clog2(NUM_OCTAVES) : 1,
  localparam int TW = $clog2(TIMEOUT_CYCLES+1)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_in,
  input  logic                   abort_in,
  input  logic                   pass_enable_in,
  input  logic                   half_done_in,
  output logic                   half_start_out,
  output logic [LW-1:0]          src_level_out,
  output logic [LW-1:0]          dst_level_out,
  output logic [NUM_OCTAVES-1:0] level_valid_out,
  output logic                   busy_out,
  output logic                   done_out,
  output logic                   timeout_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_DRAIN,
    S_FINISH
  } state_t;

  localparam logic [LW-1:0]          LAST_LEVEL  = LW'(NUM_OCTAVES-1);
  localparam logic [LW-1:0]          FIRST_DST   = LW'(1);
  localparam logic [TW-1:0]          WD_LAST     = TW'(TIMEOUT_CYCLES-1);
  localparam logic [TW-1:0]          WD_MAX      = TW'(TIMEOUT_CYCLES);
  localparam logic [NUM_OCTAVES-1:0] LEVEL0_ONLY = NUM_OCTAVES'(1);

  state_t                   state;
  logic [TW-1:0]            watchdog;
  logic [TW-1:0]            watchdog_next;
  logic                     wd_expired;
  logic [NUM_OCTAVES-1:0]   dst_mask;

  // One-hot mask of the destination level, built by compare so odd level counts index safely
  always_comb begin
    dst_mask = '0;
    for (int i = 0; i < NUM_OCTAVES; i++) begin
      if (dst_level_out == LW'(i)) dst_mask[i] = 1'b1;
    end
  end

  always_comb begin
    watchdog_next = (watchdog == WD_MAX) ? watchdog : watchdog + 1'b1;
    wd_expired    = (watchdog == WD_LAST);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state           <= S_IDLE;
      watchdog        <= '0;
      half_start_out  <= 1'b0;
      src_level_out   <= '0;
      dst_level_out   <= '0;
      level_valid_out <= '0;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
      timeout_out     <= 1'b0;
    end else begin
      half_start_out <= 1'b0;
      done_out       <= 1'b0;
      timeout_out    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start_in) begin
            level_valid_out <= LEVEL0_ONLY;
            src_level_out   <= '0;
            dst_level_out   <= FIRST_DST;
            busy_out        <= 1'b1;
            state           <= (NUM_OCTAVES == 1) ? S_FINISH : S_ARM;
          end
        end

        S_ARM: begin
          if (abort_in) begin
            busy_out <= 1'b0;
            state    <= S_IDLE;
          end else if (pass_enable_in) begin
            half_start_out <= 1'b1;
            watchdog       <= '0;
            state          <= S_WAIT;
          end
        end

        // A finished pass always counts, even if abort or the watchdog fire in the same cycle
        S_WAIT: begin
          watchdog <= watchdog_next;
          if (half_done_in) begin
            level_valid_out <= level_valid_out | dst_mask;
            if (abort_in) begin
              busy_out <= 1'b0;
              state    <= S_IDLE;
            end else if (dst_level_out == LAST_LEVEL) begin
              state <= S_FINISH;
            end else begin
              src_level_out <= src_level_out + 1'b1;
              dst_level_out <= dst_level_out + 1'b1;
              state         <= S_ARM;
            end
          end else if (wd_expired) begin
            timeout_out <= 1'b1;
            busy_out    <= 1'b0;
            state       <= S_IDLE;
          end else if (abort_in) begin
            state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          watchdog <= watchdog_next;
          if (half_done_in) begin
            busy_out <= 1'b0;
            state    <= S_IDLE;
          end else if (wd_expired) begin
            timeout_out <= 1'b1;
            busy_out    <= 1'b0;
            state       <= S_IDLE;
          end
        end

        S_FINISH: begin
          done_out <= 1'b1;
          busy_out <= 1'b0;
          state    <= S_IDLE;
        end

        default: begin
          busy_out <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pyramid_half_scheduler.sv
// Directed bench for pyramid_half_scheduler: a cycle table for a 3-level pyramid plus
// hand sequences for long passes, backpressure, timeout, drain, single level and async reset.
module tb_pyramid_half_scheduler;

  typedef struct {
    logic       start;
    logic       abort;
    logic       en;
    logic       hd;
    logic       hs;
    logic [1:0] src;
    logic [1:0] dst;
    logic [2:0] valid;
    logic       busy;
    logic       done;
    logic       to;
  } vec_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic start_in, abort_in, pass_enable_in, half_done_in, start_b;

  logic       hs_a, busy_a, done_a, to_a;
  logic [1:0] src_a, dst_a;
  logic [2:0] valid_a;
  logic       hs_b, busy_b, done_b, to_b;
  logic [0:0] src_b, dst_b, valid_b;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int hs_cnt_a = 0, done_cnt_a = 0, hs_cnt_b = 0;
  vec_t tbl[24];

  pyramid_half_scheduler #(.NUM_OCTAVES(3), .TIMEOUT_CYCLES(100)) dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .abort_in(abort_in),
    .pass_enable_in(pass_enable_in), .half_done_in(half_done_in),
    .half_start_out(hs_a), .src_level_out(src_a), .dst_level_out(dst_a),
    .level_valid_out(valid_a), .busy_out(busy_a), .done_out(done_a), .timeout_out(to_a)
  );

  pyramid_half_scheduler #(.NUM_OCTAVES(1), .TIMEOUT_CYCLES(100)) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_b), .abort_in(abort_in),
    .pass_enable_in(pass_enable_in), .half_done_in(half_done_in),
    .half_start_out(hs_b), .src_level_out(src_b), .dst_level_out(dst_b),
    .level_valid_out(valid_b), .busy_out(busy_b), .done_out(done_b), .timeout_out(to_b)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (hs_a)   hs_cnt_a++;
    if (done_a) done_cnt_a++;
    if (hs_b)   hs_cnt_b++;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual != expected) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    start_in       = v.start;
    abort_in       = v.abort;
    pass_enable_in = v.en;
    half_done_in   = v.hd;
    cycle();
  endtask

  task automatic waitHs(input string name, input int limit);
    int n = 0;
    while (!hs_a && n < limit) begin
      cycle();
      n++;
    end
    checkOutput(name, int'(hs_a), 1);
  endtask

  task automatic checkAllA(input string tag, input int hs, input int src, input int dst,
                           input int valid, input int busy, input int done, input int to);
    checkOutput({tag, "_hs"},    int'(hs_a),    hs);
    checkOutput({tag, "_src"},   int'(src_a),   src);
    checkOutput({tag, "_dst"},   int'(dst_a),   dst);
    checkOutput({tag, "_valid"}, int'(valid_a), valid);
    checkOutput({tag, "_busy"},  int'(busy_a),  busy);
    checkOutput({tag, "_done"},  int'(done_a),  done);
    checkOutput({tag, "_to"},    int'(to_a),    to);
  endtask

  task automatic pulseStart();
    start_in = 1'b1;
    cycle();
    start_in = 1'b0;
  endtask

  task automatic pulseDone();
    half_done_in = 1'b1;
    cycle();
    half_done_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL sim_time_limit: simulation still running, expected finish");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    int n;
    int hs_base, done_base, hs_b_base;
    logic saw;

    // start, abort, en, hd | hs, src, dst, valid, busy, done, timeout
    tbl[0]  = '{1'b1,1'b0,1'b1,1'b0, 1'b0,2'd0,2'd1,3'b001,1'b1,1'b0,1'b0};
    tbl[1]  = '{1'b0,1'b0,1'b1,1'b0, 1'b1,2'd0,2'd1,3'b001,1'b1,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,2'd0,2'd1,3'b001,1'b1,1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b1, 1'b0,2'd1,2'd2,3'b011,1'b1,1'b0,1'b0};
    tbl[4]  = '{1'b0,1'b0,1'b1,1'b0, 1'b1,2'd1,2'd2,3'b011,1'b1,1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b0,1'b1,1'b0, 1'b0,2'd1,2'd2,3'b011,1'b1,1'b0,1'b0};
    tbl[6]  = '{1'b0,1'b0,1'b0,1'b1, 1'b0,2'd1,2'd2,3'b111,1'b1,1'b0,1'b0};
    tbl[7]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,2'd1,2'd2,3'b111,1'b0,1'b1,1'b0};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,2'd1,2'd2,3'b111,1'b0,1'b0,1'b0};
    tbl[9]  = '{1'b0,1'b0,1'b0,1'b1, 1'b0,2'd1,2'd2,3'b111,1'b0,1'b0,1'b0};
    tbl[10] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,2'd0,2'd1,3'b001,1'b1,1'b0,1'b0};
    tbl[11] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,2'd0,2'd1,3'b001,1'b1,1'b0,1'b0};
    tbl[12] = '{1'b0,1'b1,1'b0,1'b0, 1'b0,2'd0,2'd1,3'b001,1'b0,1'b0,1'b0};
    tbl[13] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,2'd0,2'd1,3'b001,1'b0,1'b0,1'b0};
    tbl[14] = '{1'b1,1'b0,1'b1,1'b0, 1'b0,2'd0,2'd1,3'b001,1'b1,1'b0,1'b0};
    tbl[15] = '{1'b0,1'b0,1'b1,1'b0, 1'b1,2'd0,2'd1,3'b001,1'b1,1'b0,1'b0};
    tbl[16] = '{1'b0,1'b1,1'b0,1'b1, 1'b0,2'd0,2'd1,3'b011,1'b0,1'b0,1'b0};
    tbl[17] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,2'd0,2'd1,3'b011,1'b0,1'b0,1'b0};
    tbl[18] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,2'd0,2'd1,3'b001,1'b1,1'b0,1'b0};
    tbl[19] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,2'd0,2'd1,3'b001,1'b1,1'b0,1'b0};
    tbl[20] = '{1'b0,1'b0,1'b1,1'b0, 1'b1,2'd0,2'd1,3'b001,1'b1,1'b0,1'b0};
    tbl[21] = '{1'b0,1'b1,1'b0,1'b0, 1'b0,2'd0,2'd1,3'b001,1'b1,1'b0,1'b0};
    tbl[22] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,2'd0,2'd1,3'b001,1'b1,1'b0,1'b0};
    tbl[23] = '{1'b0,1'b0,1'b0,1'b1, 1'b0,2'd0,2'd1,3'b001,1'b0,1'b0,1'b0};

    start_in = 1'b0; abort_in = 1'b0; pass_enable_in = 1'b0; half_done_in = 1'b0; start_b = 1'b0;
    rst_in = 1'b0;
    cycle();
    checkAllA("reset", 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_b_busy", int'(busy_b), 0);
    rst_in = 1'b1;

    $display("[TB] cycle table");
    for (int i = 0; i < 24; i++) begin
      applyStimulus(tbl[i]);
      checkAllA($sformatf("row%0d", i), int'(tbl[i].hs), int'(tbl[i].src), int'(tbl[i].dst),
                int'(tbl[i].valid), int'(tbl[i].busy), int'(tbl[i].done), int'(tbl[i].to));
    end
    start_in = 1'b0; abort_in = 1'b0; pass_enable_in = 1'b0; half_done_in = 1'b0;
    cycle();

    $display("[TB] full build with 50-cycle passes");
    hs_base = hs_cnt_a; done_base = done_cnt_a;
    pass_enable_in = 1'b1;
    pulseStart();
    for (int p = 0; p < 2; p++) begin
      waitHs($sformatf("t1_hs%0d", p), 5);
      checkOutput($sformatf("t1_src%0d", p), int'(src_a), p);
      checkOutput($sformatf("t1_dst%0d", p), int'(dst_a), p + 1);
      repeat (49) cycle();
      pulseDone();
      checkOutput($sformatf("t1_valid%0d", p), int'(valid_a), (p == 0) ? 3 : 7);
    end
    cycle();
    checkOutput("t1_done", int'(done_a), 1);
    checkOutput("t1_busy_at_done", int'(busy_a), 0);
    cycle();
    checkOutput("t1_busy_after", int'(busy_a), 0);
    checkOutput("t1_done_after", int'(done_a), 0);
    checkOutput("t1_hs_count", hs_cnt_a - hs_base, 2);
    checkOutput("t1_done_count", done_cnt_a - done_base, 1);

    $display("[TB] backpressure between passes");
    pass_enable_in = 1'b1;
    pulseStart();
    waitHs("t2_hs_first", 5);
    repeat (10) cycle();
    pass_enable_in = 1'b0;
    pulseDone();
    checkOutput("t2_valid_mid", int'(valid_a), 3);
    saw = 1'b0;
    repeat (20) begin
      cycle();
      if (hs_a) saw = 1'b1;
    end
    checkOutput("t2_no_hs_disabled", int'(saw), 0);
    checkOutput("t2_busy_held", int'(busy_a), 1);
    pass_enable_in = 1'b1;
    waitHs("t2_hs_after_enable", 2);
    checkOutput("t2_src", int'(src_a), 1);
    checkOutput("t2_dst", int'(dst_a), 2);
    repeat (10) cycle();
    pulseDone();
    cycle();
    checkOutput("t2_done", int'(done_a), 1);
    cycle();
    checkOutput("t2_busy_end", int'(busy_a), 0);
    checkOutput("t2_valid_end", int'(valid_a), 7);

    $display("[TB] watchdog expiry");
    pass_enable_in = 1'b1;
    pulseStart();
    waitHs("t3_hs", 5);
    n = 0;
    while (!to_a && n < 150) begin
      cycle();
      n++;
    end
    checkOutput("t3_timeout_latency", n, 100);
    checkOutput("t3_busy", int'(busy_a), 0);
    checkOutput("t3_valid", int'(valid_a), 1);
    cycle();
    checkOutput("t3_timeout_pulse", int'(to_a), 0);

    $display("[TB] abort with drain");
    hs_base = hs_cnt_a; done_base = done_cnt_a;
    pulseStart();
    waitHs("t4_hs", 5);
    repeat (5) cycle();
    abort_in = 1'b1;
    cycle();
    abort_in = 1'b0;
    checkOutput("t4_busy_drain", int'(busy_a), 1);
    saw = 1'b0;
    repeat (29) begin
      cycle();
      if (!busy_a) saw = 1'b1;
    end
    checkOutput("t4_busy_dropped", int'(saw), 0);
    checkOutput("t4_valid_drain", int'(valid_a), 1);
    pulseDone();
    checkOutput("t4_busy_end", int'(busy_a), 0);
    checkOutput("t4_valid_end", int'(valid_a), 1);
    cycle();
    checkOutput("t4_no_done", done_cnt_a - done_base, 0);
    checkOutput("t4_hs_count", hs_cnt_a - hs_base, 1);

    $display("[TB] single-level pyramid");
    hs_b_base = hs_cnt_b;
    start_b = 1'b1;
    cycle();
    start_b = 1'b0;
    checkOutput("t5_b_busy", int'(busy_b), 1);
    checkOutput("t5_b_valid", int'(valid_b), 1);
    cycle();
    checkOutput("t5_b_done", int'(done_b), 1);
    checkOutput("t5_b_busy_at_done", int'(busy_b), 0);
    cycle();
    checkOutput("t5_b_done_pulse", int'(done_b), 0);
    checkOutput("t5_b_no_hs", hs_cnt_b - hs_b_base, 0);

    $display("[TB] async reset mid-pass");
    pass_enable_in = 1'b1;
    pulseStart();
    waitHs("t6_hs_before", 5);
    repeat (5) cycle();
    #2;
    rst_in = 1'b0;
    #1;
    checkAllA("t6_reset", 0, 0, 0, 0, 0, 0, 0);
    cycle();
    rst_in = 1'b1;
    pulseStart();
    checkOutput("t6_busy_restart", int'(busy_a), 1);
    checkOutput("t6_valid_restart", int'(valid_a), 1);
    waitHs("t6_hs_restart", 3);
    checkOutput("t6_src", int'(src_a), 0);
    checkOutput("t6_dst", int'(dst_a), 1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
